// File: rtl/barrel_rot_pkg.sv
// barrel_rot_pkg: mode encodings shared by the rotator pipeline and its stages.
package barrel_rot_pkg;

    localparam logic [1:0] MODE_ROTR = 2'd0;
    localparam logic [1:0] MODE_ROTL = 2'd1;
    localparam logic [1:0] MODE_SHR  = 2'd2;
    localparam logic [1:0] MODE_SHL  = 2'd3;

    typedef enum logic [1:0] {
        ROT_R = MODE_ROTR,
        ROT_L = MODE_ROTL,
        SH_R  = MODE_SHR,
        SH_L  = MODE_SHL
    } rot_mode_t;

endpackage

// File: rtl/barrel_rot_stage.sv
// barrel_rot_stage: one pipeline slice of the barrel rotator. Moves the item by
// 2^STEP when amount bit STEP is set, registers it, and carries tag/mode/amount.
// With BARREL_ROT_XOR_EN defined it also carries the original operand and xor flag.
module barrel_rot_stage
    import barrel_rot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int STEP  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [WIDTH-1:0]         up_data,
    input  logic [$clog2(WIDTH)-1:0] up_amt,
    input  rot_mode_t                up_mode,
    input  logic [TAG_W-1:0]         up_tag,
`ifdef BARREL_ROT_XOR_EN
    input  logic [WIDTH-1:0]         up_orig,
    input  logic                     up_xor,
    output logic [WIDTH-1:0]         dn_orig,
    output logic                     dn_xor,
`endif
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [WIDTH-1:0]         dn_data,
    output logic [$clog2(WIDTH)-1:0] dn_amt,
    output rot_mode_t                dn_mode,
    output logic [TAG_W-1:0]         dn_tag
);

    localparam int SH = 1 << STEP;

    logic [WIDTH-1:0] moved;

    // Bubble-collapsing ready: an empty slot can always take a new item.
    assign up_ready = !dn_valid || dn_ready;

    // Conditional move by 2^STEP; ROTL never reaches here (converted at the input).
    always_comb begin
        moved = up_data;
        if (up_amt[STEP]) begin
            case (up_mode)
                SH_R:    moved = up_data >> SH;
                SH_L:    moved = up_data << SH;
                default: moved = (up_data >> SH) | (up_data << (WIDTH - SH));
            endcase
        end
    end

    // Register slice: load whenever this slot is free or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_amt   <= '0;
            dn_mode  <= ROT_R;
            dn_tag   <= '0;
`ifdef BARREL_ROT_XOR_EN
            dn_orig  <= '0;
            dn_xor   <= 1'b0;
`endif
        end else if (up_ready) begin
            dn_valid <= up_valid;
            dn_data  <= moved;
            dn_amt   <= up_amt;
            dn_mode  <= up_mode;
            dn_tag   <= up_tag;
`ifdef BARREL_ROT_XOR_EN
            dn_orig  <= up_orig;
            dn_xor   <= up_xor;
`endif
        end
    end

endmodule

// File: rtl/barrel_rot_pipe.sv
// barrel_rot_pipe: pipelined barrel rotator/shifter, one registered stage per
// amount bit, valid/ready on both sides. Optional feature macro BARREL_ROT_XOR_EN
// adds in_xor: out_data = result ^ original operand (for sigma terms).
module barrel_rot_pipe
    import barrel_rot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
`ifdef BARREL_ROT_XOR_EN
    input  logic                     in_xor,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int AMT_W = $clog2(WIDTH);

    // Index 0 is the input side, index k+1 is the output of stage k.
    logic [AMT_W:0]            vld;
    logic [AMT_W:0]            rdy;
    logic [AMT_W:0][WIDTH-1:0] dat;
    logic [AMT_W:0][AMT_W-1:0] amt;
    logic [AMT_W:0][TAG_W-1:0] tag;
    rot_mode_t                 mode [AMT_W+1];
`ifdef BARREL_ROT_XOR_EN
    logic [AMT_W:0][WIDTH-1:0] org;
    logic [AMT_W:0]            xr;
`endif

    // ROTL by n is ROTR by (WIDTH-n) mod WIDTH; the amount wraps naturally.
    assign vld[0]  = in_valid;
    assign dat[0]  = in_data;
    assign tag[0]  = in_tag;
    assign amt[0]  = (in_mode == MODE_ROTL) ? AMT_W'(-in_amt) : in_amt;
    assign mode[0] = (in_mode == MODE_ROTL) ? ROT_R : rot_mode_t'(in_mode);
`ifdef BARREL_ROT_XOR_EN
    assign org[0]  = in_data;
    assign xr[0]   = in_xor;
`endif

    assign in_ready   = rdy[0];
    assign rdy[AMT_W] = out_ready;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        barrel_rot_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .STEP  (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (dat[k]),
            .up_amt   (amt[k]),
            .up_mode  (mode[k]),
            .up_tag   (tag[k]),
`ifdef BARREL_ROT_XOR_EN
            .up_orig  (org[k]),
            .up_xor   (xr[k]),
            .dn_orig  (org[k+1]),
            .dn_xor   (xr[k+1]),
`endif
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (dat[k+1]),
            .dn_amt   (amt[k+1]),
            .dn_mode  (mode[k+1]),
            .dn_tag   (tag[k+1])
        );
    end

    // Amount and mode are spent once the last stage has moved the data.
    logic unused_tail;
    assign unused_tail = ^{amt[AMT_W], mode[AMT_W]};

    assign out_valid = vld[AMT_W];
    assign out_tag   = tag[AMT_W];
`ifdef BARREL_ROT_XOR_EN
    assign out_data  = xr[AMT_W] ? (dat[AMT_W] ^ org[AMT_W]) : dat[AMT_W];
`else
    assign out_data  = dat[AMT_W];
`endif

endmodule

// File: tb/tb_barrel_rot_pipe.sv
// tb_barrel_rot_pipe: directed vectors, expected results queued at acceptance and
// checked by an independent output monitor.
module tb_barrel_rot_pipe;
    import barrel_rot_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic [4:0]       in_amt = '0;
    logic [1:0]       in_mode = '0;
    logic [3:0]       in_tag = '0;
`ifdef BARREL_ROT_XOR_EN
    logic             in_xor = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [3:0]       out_tag;

    barrel_rot_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
`ifdef BARREL_ROT_XOR_EN
        .in_xor    (in_xor),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Output monitor: compare every result transfer against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    if (e.chk_lat) chk("latency", 32'(cyc - e.acc), 32'(LAT));
                end
            end
        end
    end

    task automatic offer(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                         input logic [3:0] t, input logic x, input logic [31:0] exp,
                         input bit lat, output bit ok);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_tag   = t;
`ifdef BARREL_ROT_XOR_EN
        in_xor   = x;
`else
        if (x) in_tag = t;
`endif
        #1;
        ok = in_ready;
        if (ok) begin
            e.data = exp; e.tag = t; e.acc = cyc; e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                        input logic [3:0] t, input logic x, input logic [31:0] exp, input bit lat);
        bit ok;
        for (int n = 0; n < 50; n++) begin
            offer(d, a, m, t, x, exp, lat, ok);
            if (ok) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", t);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int          idx;
        int          tries;
        bit          ok;
        logic [31:0] sd;
        logic [3:0]  st;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_tag", 32'(out_tag), 32'd0);

        // Directed vectors, mixed modes back to back
        send(32'h80000001, 5'd17, MODE_ROTR, 4'd1, 1'b0, 32'h0000C000, 1'b1);
        send(32'h80000001, 5'd17, MODE_ROTL, 4'd2, 1'b0, 32'h00030000, 1'b1);
        send(32'hF000000F, 5'd4,  MODE_SHR,  4'd3, 1'b0, 32'h0F000000, 1'b1);
        send(32'hF000000F, 5'd4,  MODE_SHL,  4'd4, 1'b0, 32'h000000F0, 1'b1);
        send(32'hF000000F, 5'd0,  MODE_ROTR, 4'd5, 1'b0, 32'hF000000F, 1'b1);
        send(32'hF000000F, 5'd0,  MODE_ROTL, 4'd6, 1'b0, 32'hF000000F, 1'b1);
        send(32'hF000000F, 5'd0,  MODE_SHR,  4'd7, 1'b0, 32'hF000000F, 1'b1);
        send(32'hF000000F, 5'd0,  MODE_SHL,  4'd8, 1'b0, 32'hF000000F, 1'b1);
        send(32'h80000001, 5'd31, MODE_SHR,  4'd9, 1'b0, 32'h00000001, 1'b1);
        send(32'h80000001, 5'd31, MODE_SHL,  4'hA, 1'b0, 32'h80000000, 1'b1);
        send(32'h80000001, 5'd31, MODE_ROTL, 4'hB, 1'b0, 32'hC0000000, 1'b1);
        send(32'h80000001, 5'd31, MODE_ROTR, 4'hC, 1'b0, 32'h00000003, 1'b1);
`ifdef BARREL_ROT_XOR_EN
        send(32'h80000001, 5'd17, MODE_ROTR, 4'hD, 1'b1, 32'h8000C001, 1'b1);
        send(32'h80000001, 5'd17, MODE_ROTR, 4'hE, 1'b0, 32'h0000C000, 1'b1);
`endif
        idle();
        drain();

        // Streaming: 32 items back to back, one accepted per offer
        tries = 0;
        for (int i = 0; i < 32; i++) begin
            offer(32'h1, 5'(i), MODE_ROTR, 4'(i), 1'b0, 32'h1 << ((32 - i) % 32), 1'b1, ok);
            tries++;
            while (!ok && tries < 200) begin
                offer(32'h1, 5'(i), MODE_ROTR, 4'(i), 1'b0, 32'h1 << ((32 - i) % 32), 1'b1, ok);
                tries++;
            end
        end
        idle();
        chk("stream_offers", 32'(tries), 32'd32);
        drain();

        // Backpressure: only five slots exist
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int n = 0; n < 12 && idx < 7; n++) begin
            offer({8'hA0 + 8'(idx), 24'h0}, 5'd24, MODE_SHR, 4'(idx + 8), 1'b0,
                  32'(8'hA0 + 8'(idx)), 1'b0, ok);
            if (ok) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd5);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        sd = out_data;
        st = out_tag;
        chk("bp_head_data", sd, 32'h000000A0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            chk("bp_stable_data", out_data, sd);
            chk("bp_stable_tag", 32'(out_tag), 32'(st));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = idx; i < 7; i++)
            send({8'hA0 + 8'(i), 24'h0}, 5'd24, MODE_SHR, 4'(i + 8), 1'b0, 32'(8'hA0 + 8'(i)), 1'b0);
        idle();
        drain();

        // Reset with three items in flight, head item waiting at the output
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h00000010, 5'd4, MODE_SHR, 4'd1, 1'b0, 32'h00000001, 1'b0);
        send(32'h00000020, 5'd4, MODE_SHR, 4'd2, 1'b0, 32'h00000002, 1'b0);
        send(32'h00000030, 5'd4, MODE_SHR, 4'd3, 1'b0, 32'h00000003, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rel_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);
        send(32'h12345678, 5'd8, MODE_ROTR, 4'hF, 1'b0, 32'h78123456, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
